// File: rtl/serial_word_feeder.sv
`default_nettype none
// ============================================================================
// Module      : serial_word_feeder
// Description : Parallel-to-serial feeder, LSB first, with a one-word holding
//               register so consecutive words stream without idle cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_word_feeder #(
    parameter int WIDTH = 8
) (
    input  logic             t_clk,
    input  logic             r,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_i,
    output logic             ser_r,
    output logic             ser_valid,
    output logic             ser_last
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_CNT_LAST   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_CNT_PENULT = CNT_W'(WIDTH - 2);
    localparam logic [CNT_W-1:0] c_CNT_ONE    = CNT_W'(1);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_SHIFT = 1'b1;

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_full;
    logic [WIDTH-1:0] r_sreg;
    logic             r_ser_i;
    logic             r_ser_r;
    logic             r_ser_valid;
    logic             r_ser_last;

    logic w_last_bit;
    logic w_load;
    logic w_accept;

    assign w_last_bit = (r_state == c_ST_SHIFT) && (r_cnt == c_CNT_LAST);
    // Loading on the last-bit edge is what removes the gap between words.
    assign w_load     = r_hold_full && ((r_state == c_ST_IDLE) || w_last_bit);
    // Accept and load are exclusive: accept needs the holding register empty.
    assign w_accept   = in_valid && !r_hold_full;

    always_ff @(posedge t_clk) begin
        if (r) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_sreg      <= '0;
            r_ser_i     <= 1'b0;
            r_ser_r     <= 1'b0;
            r_ser_valid <= 1'b0;
            r_ser_last  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_hold      <= in_data;
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end

            if (w_load) begin
                r_ser_i     <= r_hold[0];
                r_ser_r     <= 1'b1;
                r_ser_valid <= 1'b1;
                r_ser_last  <= 1'b0;
                r_sreg      <= r_hold >> 1;
                r_cnt       <= '0;
                r_state     <= c_ST_SHIFT;
            end else if (r_state == c_ST_SHIFT) begin
                if (r_cnt != c_CNT_LAST) begin
                    r_ser_i     <= r_sreg[0];
                    r_sreg      <= r_sreg >> 1;
                    r_cnt       <= r_cnt + c_CNT_ONE;
                    r_ser_r     <= 1'b0;
                    r_ser_last  <= (r_cnt == c_CNT_PENULT);
                end else begin
                    r_state     <= c_ST_IDLE;
                    r_ser_i     <= 1'b0;
                    r_ser_r     <= 1'b0;
                    r_ser_valid <= 1'b0;
                    r_ser_last  <= 1'b0;
                end
            end
        end
    end

    assign in_ready  = ~r_hold_full;
    assign ser_i     = r_ser_i;
    assign ser_r     = r_ser_r;
    assign ser_valid = r_ser_valid;
    assign ser_last  = r_ser_last;

endmodule
`default_nettype wire
